// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a final cycle.
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo writes accepted
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_FIX  | apply result signs, commit hi/lo, pulse done
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Signed ops work on magnitudes; the most negative value maps to itself as an unsigned magnitude.
  always_comb begin
    abs_a = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  // acc_hi/acc_lo hold partial product + multiplier, or remainder + dividend/quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix   = neg_res ? -acc_lo : acc_lo;
    rem_fix   = neg_rem ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_res  <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem  <= op[0] & src_a[WIDTH-1];
            div_zero <= (src_b == '0);
            acc_hi   <= '0;
            acc_lo   <= op[1] ? abs_a : abs_b;
            opnd     <= op[1] ? abs_b : abs_a;
            cnt      <= CW'(WIDTH - 1);
            busy     <= 1'b1;
            state    <= op[1] ? S_DIV : S_MUL;
          end else begin
            if (mthi) hi <= src_a;
            if (mtlo) lo <= src_a;
          end
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_DIV: begin
          acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          // Divide by zero leaves the remainder equal to the dividend; only the quotient is forced.
          if (is_div) begin
            lo <= div_zero ? '1 : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: vector table through a result scoreboard,
// plus hand sequences for busy-time input drops, held start and mid-op reset.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  mdu_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive an op for the E0 edge; returns at the negedge after E0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit push, input bit hold, input bit with_mthi);
    exp_t e;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1; mthi = with_mthi;
    if (push) begin
      e.hi = eh; e.lo = el;
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
    mthi  = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    chk("launch_busy", {63'd0, busy}, 64'd1);
  endtask

  // Waits for done, checking busy and hi/lo hold each cycle; poke>0 pulses start+mtlo at that cycle.
  task automatic wait_done(input int poke);
    logic [31:0] h0, l0;
    int bad, k;
    exp_t e;
    h0 = hi; l0 = lo; bad = 0;
    for (k = 1; k <= 40; k++) begin
      if (k == poke) begin
        start = 1'b1; op = 2'b10; mtlo = 1'b1; src_a = 32'h1234;
      end
      @(negedge clk);
      if (k == poke) begin
        start = 1'b0; mtlo = 1'b0;
      end
      if (done) break;
      if (!busy || hi !== h0 || lo !== l0) bad++;
    end
    chk("latency", 64'(k), 64'd33);
    chk("busy_hold", 64'(bad), 64'd0);
    if (done) begin
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
      end
    end else begin
      chk("done_timeout", 64'd0, 64'd1);
    end
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int ndone;
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6]  = '{2'b00, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};
    vecs[7]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{2'b01, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi",   {32'd0, hi},   64'd0);
    chk("rst_lo",   {32'd0, lo},   64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1, 1'b0, 1'b0);
      wait_done(0);
    end

    // IDLE moves: both together, then each alone
    src_a = 32'h5555; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_both", {32'd0, hi}, 64'h5555);
    chk("mtlo_both", {32'd0, lo}, 64'h5555);
    src_a = 32'hA0A0; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_only_hi", {32'd0, hi}, 64'h5555);
    chk("mtlo_only_lo", {32'd0, lo}, 64'hA0A0);

    // start/mtlo while busy are dropped
    launch(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 1'b0, 1'b0);
    wait_done(5);
    chk("no_queued_op", {63'd0, busy}, 64'd0);

    // start beats mthi in the same cycle; hold check inside wait_done sees hi unchanged
    launch(2'b00, 32'hAAAA, 32'd3, 32'd0, 32'h1FFFE, 1'b1, 1'b0, 1'b1);
    wait_done(0);

    // start held high: next op launches on the edge after done
    launch(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1, 1'b1, 1'b0);
    src_a = 32'd9; src_b = 32'd5; op = 2'b10;
    wait_done(0);
    start = 1'b0;
    chk("held_relaunch", {63'd0, busy}, 64'd1);
    sb.push_back('{32'd4, 32'd1});
    wait_done(0);

    // reset mid-op aborts with no done pulse
    launch(2'b01, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi",   {32'd0, hi},   64'd0);
    chk("abort_lo",   {32'd0, lo},   64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
